muldiv_unit: RTL

Iterative multi-cycle multiply/divide unit for the RISC-V pipeline's execute stage. It consumes the 4-bit ALU select code produced by the ALU-control decoder and handles the three codes the single-cycle ALU does not: mul, div and rem. It runs a start/busy/done handshake so the hazard unit can stall the pipeline while an operation is in flight.

---
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit - iterative RV32 mul/div/rem (shift-add, restoring)  Rev 1.0
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       alusel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [3:0]       C_SEL_MUL = 4'b1011;
  localparam logic [3:0]       C_SEL_DIV = 4'b1110;
  localparam logic [3:0]       C_SEL_REM = 4'b0010;
  localparam int               CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]    C_LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] C_MIN     = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_opa;     // multiplicand (shifted left) / dividend shifting into quotient
  logic [WIDTH-1:0] r_opb;     // multiplier (shifted right) / divisor magnitude
  logic [WIDTH-1:0] r_acc;     // product accumulator / partial remainder
  logic             r_rem_sel;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_is_mul;
  logic             w_is_div;
  logic             w_is_rem;
  logic             w_accept;
  logic             w_div_zero;
  logic             w_div_ovf;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_mul_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_quo_signed;
  logic [WIDTH-1:0] w_rem_signed;

  assign w_is_mul   = (alusel == C_SEL_MUL);
  assign w_is_div   = (alusel == C_SEL_DIV);
  assign w_is_rem   = (alusel == C_SEL_REM);
  assign w_accept   = start & (w_is_mul | w_is_div | w_is_rem);
  assign w_div_zero = (b == '0);
  assign w_div_ovf  = (a == C_MIN) && (b == '1);
  assign w_abs_a    = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign w_abs_b    = b[WIDTH-1] ? (~b + 1'b1) : b;

  assign w_mul_sum  = r_acc + (r_opb[0] ? r_opa : '0);

  // The trial subtraction is one bit wider so its borrow shows up as the sign bit.
  assign w_rem_sh     = {r_acc, r_opa[WIDTH-1]};
  assign w_trial      = w_rem_sh - {1'b0, r_opb};
  assign w_q_bit      = ~w_trial[WIDTH];
  assign w_rem_next   = w_q_bit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_next   = {r_opa[WIDTH-2:0], w_q_bit};
  assign w_quo_signed = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
  assign w_rem_signed = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

  assign busy = r_busy;
  assign done = r_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      result    <= '0;
      r_cnt     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_rem_sel <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_rem_sel <= w_is_rem;
            r_neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg_r   <= a[WIDTH-1];
            if (w_is_mul) begin
              r_opa   <= a;
              r_opb   <= b;
              r_state <= S_MUL;
              r_busy  <= 1'b1;
            end else if (w_div_zero) begin
              r_opa   <= a;
              r_opb   <= b;
              result  <= w_is_rem ? a : '1;
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (w_div_ovf) begin
              r_opa   <= a;
              r_opb   <= b;
              result  <= w_is_rem ? '0 : C_MIN;
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_opa   <= w_abs_a;
              r_opb   <= w_abs_b;
              r_state <= S_DIV;
              r_busy  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_sum;
          r_opa <= r_opa << 1;
          r_opb <= r_opb >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            result  <= w_mul_sum;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DIV: begin
          r_acc <= w_rem_next;
          r_opa <= w_quo_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            result  <= r_rem_sel ? w_rem_signed : w_quo_signed;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
